// File: rtl/t07_simon_pkg.sv
// t07_simon_pkg: shared playback states and default timing/size constants
// ports: none (package)
package t07_simon_pkg;
   localparam int DEF_NUM_COLORS = 4;
   localparam int DEF_MAX_LEN    = 8;
   localparam int DEF_LEAD_TICKS = 3;
   localparam int DEF_ON_TICKS   = 2;
   localparam int DEF_GAP_TICKS  = 1;
   typedef enum logic [2:0] {IDLE, LEAD, ON, GAP, CLEAR} state_t;
endpackage

// File: rtl/t07_simon_light_player_if.sv
// t07_simon_light_player_if: control, sequence and light bundle of the Simon player
// ports: master drives tick/play/play_len/abort/cleared/seq_bus/button and reads
//        light_seq/light_manual/busy/done; slave is the player side
interface t07_simon_light_player_if
   import t07_simon_pkg::*;
#(
   parameter int NUM_COLORS = DEF_NUM_COLORS,
   parameter int MAX_LEN    = DEF_MAX_LEN
) ();
   localparam int CW = $clog2(NUM_COLORS);
   localparam int LW = $clog2(MAX_LEN + 1);
   logic                    tick;
   logic                    play;
   logic [LW-1:0]           play_len;
   logic                    abort;
   logic                    cleared;
   logic [MAX_LEN*CW-1:0]   seq_bus;
   logic [NUM_COLORS-1:0]   button;
   logic [NUM_COLORS-1:0]   light_seq;
   logic [NUM_COLORS-1:0]   light_manual;
   logic                    busy;
   logic                    done;
   modport master (
      output tick, play, play_len, abort, cleared, seq_bus, button,
      input  light_seq, light_manual, busy, done
   );
   modport slave (
      input  tick, play, play_len, abort, cleared, seq_bus, button,
      output light_seq, light_manual, busy, done
   );
endinterface

// File: rtl/t07_simon_tick_timer.sv
// t07_simon_tick_timer: down-counter of tick strobes for one playback phase
// ports: clk, rst (async, active high), load/load_val (reload on phase entry),
//        tick (count enable), expired (this tick ends the loaded period)
module t07_simon_tick_timer
   import t07_simon_pkg::*;
#(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         tick,
   output logic         expired
);
   logic [W-1:0] cnt;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt <= '0;
      else if (load) cnt <= load_val;
      else if (tick && cnt != '0) cnt <= cnt - W'(1);
   end
   // flags the tick that would bring the count to zero, so the phase change lands on that edge
   assign expired = tick && cnt == W'(1);
endmodule

// File: rtl/t07_simon_light_player.sv
// t07_simon_light_player: plays a stored color sequence as timed one-hot light flashes
// ports: clk, rst (async, active high), bus (slave): tick strobe, play/play_len start,
//        abort, cleared override, seq_bus entries, button echo; light_seq, light_manual,
//        busy, done outputs
module t07_simon_light_player
   import t07_simon_pkg::*;
#(
   parameter int NUM_COLORS = DEF_NUM_COLORS,
   parameter int MAX_LEN    = DEF_MAX_LEN,
   parameter int LEAD_TICKS = DEF_LEAD_TICKS,
   parameter int ON_TICKS   = DEF_ON_TICKS,
   parameter int GAP_TICKS  = DEF_GAP_TICKS
) (
   input logic clk,
   input logic rst,
   t07_simon_light_player_if.slave bus
);
   localparam int CW = $clog2(NUM_COLORS);
   localparam int LW = $clog2(MAX_LEN + 1);
   localparam int TW = $clog2(LEAD_TICKS + ON_TICKS + GAP_TICKS + 2);
   state_t                state;
   logic [LW-1:0]         idx, len, idx_n;
   logic [MAX_LEN*CW-1:0] snap;
   logic                  ld, expired, start, last, to_gap;
   logic [TW-1:0]         ld_val;
   logic [NUM_COLORS-1:0] first_lit, next_lit;
   // out-of-range color codes light nothing; the extra bit keeps the compare non-constant
   function automatic logic [NUM_COLORS-1:0] onehot(input logic [CW-1:0] v);
      return ({1'b0, v} < (CW+1)'(NUM_COLORS)) ? NUM_COLORS'(1) << v : '0;
   endfunction
   assign start     = bus.play && bus.play_len != '0;
   assign last      = idx == len - LW'(1);
   assign idx_n     = idx + LW'(1);
   assign to_gap    = state == ON && GAP_TICKS != 0;
   assign first_lit = onehot(bus.seq_bus[0 +: CW]);
   assign next_lit  = onehot(snap[int'(idx_n)*CW +: CW]);
   assign bus.light_manual = $onehot(bus.button) ? bus.button : '0;
   // reload the timer on every state entry with the length of the phase being entered
   always_comb begin
      ld = 1'b0;
      ld_val = '0;
      if (bus.cleared || state == CLEAR) ld = !(bus.cleared && state == CLEAR);
      else if (state == IDLE) begin
         ld = start;
         ld_val = TW'(LEAD_TICKS != 0 ? LEAD_TICKS : ON_TICKS);
      end else if (bus.abort) ld = 1'b1;
      else if (expired) begin
         ld = 1'b1;
         ld_val = state != ON ? TW'(ON_TICKS) : last ? '0 : TW'(GAP_TICKS != 0 ? GAP_TICKS : ON_TICKS);
      end
   end
   t07_simon_tick_timer #(.W(TW)) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (ld),
      .load_val (ld_val),
      .tick     (bus.tick),
      .expired  (expired)
   );
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         idx           <= '0;
         len           <= '0;
         snap          <= '0;
         bus.light_seq <= '0;
         bus.busy      <= 1'b0;
         bus.done      <= 1'b0;
      end else begin
         bus.done <= 1'b0;
         if (bus.cleared) begin
            state         <= CLEAR;
            bus.light_seq <= '1;
            bus.busy      <= 1'b0;
         end else if (state == CLEAR) begin
            state         <= IDLE;
            bus.light_seq <= '0;
         end else if (state == IDLE) begin
            if (start) begin
               snap          <= bus.seq_bus;
               len           <= bus.play_len > LW'(MAX_LEN) ? LW'(MAX_LEN) : bus.play_len;
               idx           <= '0;
               bus.busy      <= 1'b1;
               state         <= LEAD_TICKS != 0 ? LEAD : ON;
               bus.light_seq <= LEAD_TICKS != 0 ? '0 : first_lit;
            end
         end else if (bus.abort || (expired && state == ON && last)) begin
            state         <= IDLE;
            bus.light_seq <= '0;
            bus.busy      <= 1'b0;
            bus.done      <= !bus.abort;
         end else if (expired) begin
            state         <= to_gap ? GAP : ON;
            idx           <= state == LEAD ? '0 : to_gap ? idx : idx_n;
            bus.light_seq <= to_gap ? '0 : state == LEAD ? onehot(snap[0 +: CW]) : next_lit;
         end
      end
   end
endmodule

// File: tb/tb_t07_simon_light_player.sv
// tb_t07_simon_light_player: random and directed checks against a segment-queue model
module tb_t07_simon_light_player;
   localparam int NC = 4, ML = 8, LEAD = 3, ONT = 2, GAPT = 1;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic tick_rand = 1'b0;
   int   tests = 0, fails = 0, cyc = 0;
   logic [3:0] m_light = '0;
   logic       m_busy = 1'b0, m_done = 1'b0, m_clr = 1'b0;
   int         m_rem = 0;
   logic [3:0] seg_l[$];
   int         seg_t[$];
   logic [3:0] exp_q[$];
   t07_simon_light_player_if #(.NUM_COLORS(NC), .MAX_LEN(ML)) bus ();
   t07_simon_light_player #(
      .NUM_COLORS(NC), .MAX_LEN(ML), .LEAD_TICKS(LEAD), .ON_TICKS(ONT), .GAP_TICKS(GAPT)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );
   always #5 clk = ~clk;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask
   // model: a playback is a queue of (lights, tick count) segments consumed by ticks
   task automatic model_reset();
      m_light = '0; m_busy = 1'b0; m_done = 1'b0; m_clr = 1'b0; m_rem = 0;
      seg_l.delete(); seg_t.delete();
   endtask
   task automatic model_start();
      int n;
      logic [1:0] e;
      n = bus.play_len > ML ? ML : int'(bus.play_len);
      seg_l.delete(); seg_t.delete();
      if (LEAD > 0) begin seg_l.push_back(4'b0000); seg_t.push_back(LEAD); end
      for (int i = 0; i < n; i++) begin
         if (i > 0 && GAPT > 0) begin seg_l.push_back(4'b0000); seg_t.push_back(GAPT); end
         e = bus.seq_bus[i*2 +: 2];
         seg_l.push_back(4'b0001 << e);
         seg_t.push_back(ONT);
      end
      m_busy = 1'b1; m_light = seg_l[0]; m_rem = seg_t[0];
   endtask
   task automatic model_step();
      m_done = 1'b0;
      if (bus.cleared) begin
         m_clr = 1'b1; m_light = 4'b1111; m_busy = 1'b0; seg_l.delete(); seg_t.delete();
      end else if (m_clr) begin
         m_clr = 1'b0; m_light = '0;
      end else if (!m_busy) begin
         if (bus.play && bus.play_len != 0) model_start();
      end else if (bus.abort) begin
         m_busy = 1'b0; m_light = '0; seg_l.delete(); seg_t.delete();
      end else if (bus.tick) begin
         m_rem--;
         if (m_rem == 0) begin
            void'(seg_l.pop_front()); void'(seg_t.pop_front());
            if (seg_l.size() == 0) begin
               m_busy = 1'b0; m_light = '0; m_done = 1'b1;
            end else begin
               m_light = seg_l[0]; m_rem = seg_t[0];
            end
         end
      end
   endtask
   initial forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else model_step();
   end
   initial forever begin
      @(negedge clk);
      chk("cycle", 32'({bus.light_seq, bus.busy, bus.done, bus.light_manual}),
          32'({m_light, m_busy, m_done, ($countones(bus.button) == 1 ? bus.button : 4'b0000)}));
   end
   initial forever begin
      @(negedge clk);
      #1;
      cyc++;
      bus.tick = tick_rand ? ($urandom_range(0, 2) == 0) : (cyc % 4 == 0);
   end
   initial begin
      #1000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end
   task automatic play_seq(input logic [3:0] len, input logic [15:0] s);
      @(negedge clk); #1;
      bus.play = 1'b1; bus.play_len = len; bus.seq_bus = s;
      @(negedge clk); #1;
      bus.play = 1'b0;
   endtask
   task automatic run_pin(input string nm);
      logic hit;
      for (int k = 0; k < exp_q.size(); k++) begin
         hit = 1'b0;
         for (int i = 0; i < 20 && !hit; i++) begin
            @(posedge clk);
            hit = bus.tick;
         end
         @(negedge clk);
         chk(nm, 32'({hit, bus.light_seq, bus.done, bus.busy}),
             32'({1'b1, exp_q[k], k == exp_q.size() - 1, k != exp_q.size() - 1}));
      end
   endtask
   task automatic wait_lit(input string nm, input logic want_lit);
      logic found;
      found = 1'b0;
      for (int i = 0; i < 60 && !found; i++) begin
         @(negedge clk);
         found = want_lit ? bus.light_seq != 0 : (bus.light_seq == 0 && bus.busy);
      end
      chk(nm, 32'(found), 32'd1);
   endtask
   initial begin
      logic found, prev_lit;
      int   flashes, dones;
      bus.tick = 1'b0; bus.play = 1'b0; bus.play_len = '0; bus.abort = 1'b0;
      bus.cleared = 1'b0; bus.seq_bus = '0; bus.button = '0;
      repeat (3) @(negedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset_state", 32'({bus.light_seq, bus.busy, bus.done}), 32'd0);
      play_seq(4'd3, 16'h0022);
      exp_q = '{4'b0000, 4'b0000, 4'b0100, 4'b0100, 4'b0000, 4'b0001, 4'b0001,
                4'b0000, 4'b0100, 4'b0100, 4'b0000};
      run_pin("seq_2_0_2");
      @(negedge clk);
      chk("done_single_cycle", 32'({bus.done, bus.busy}), 32'd0);
      play_seq(4'd2, 16'h0005);
      exp_q = '{4'b0000, 4'b0000, 4'b0010, 4'b0010, 4'b0000, 4'b0010, 4'b0010, 4'b0000};
      run_pin("seq_1_1");
      @(negedge clk); #1 bus.button = 4'b0100;
      @(negedge clk);
      chk("manual_onehot", 32'(bus.light_manual), 32'h4);
      #1 bus.button = 4'b0110;
      @(negedge clk);
      chk("manual_two_bits", 32'(bus.light_manual), 32'h0);
      #1 bus.button = 4'b0000;
      play_seq(4'd3, 16'h0039);
      wait_lit("reach_on_for_clear", 1'b1);
      #1 bus.cleared = 1'b1;
      @(negedge clk);
      chk("clear_on", 32'({bus.light_seq, bus.busy, bus.done}), 32'({4'b1111, 2'b00}));
      repeat (3) @(negedge clk);
      #1 bus.cleared = 1'b0;
      @(negedge clk);
      chk("clear_release", 32'({bus.light_seq, bus.busy}), 32'd0);
      dones = 0;
      repeat (30) begin @(negedge clk); dones += int'(bus.done); end
      chk("no_done_after_clear", 32'(dones), 32'd0);
      play_seq(4'd3, 16'h0024);
      wait_lit("reach_on_for_abort", 1'b1);
      wait_lit("reach_gap", 1'b0);
      #1 bus.abort = 1'b1;
      @(negedge clk);
      chk("abort_gap", 32'({bus.light_seq, bus.busy, bus.done}), 32'd0);
      #1 bus.abort = 1'b0;
      play_seq(4'd1, 16'h0003);
      found = 1'b0;
      for (int i = 0; i < 60 && !found; i++) begin @(negedge clk); found = bus.done; end
      chk("len1_after_abort_done", 32'(found), 32'd1);
      play_seq(4'd0, 16'h00ff);
      @(negedge clk);
      chk("len0_ignored", 32'(bus.busy), 32'd0);
      play_seq(4'd12, 16'($urandom));
      flashes = 0; prev_lit = 1'b0; found = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
         @(negedge clk);
         if (bus.light_seq != 0 && !prev_lit) flashes++;
         prev_lit = bus.light_seq != 0;
         found = bus.done;
         if (i == 10) begin #1 bus.play = 1'b1; bus.play_len = 4'd1; end
         if (i == 11) begin #1 bus.play = 1'b0; end
      end
      chk("len12_done", 32'(found), 32'd1);
      chk("len12_flashes", 32'(flashes), 32'd8);
      play_seq(4'd2, 16'h0006);
      wait_lit("reach_on_for_rst", 1'b1);
      #1 rst = 1'b1;
      #1 chk("rst_async", 32'({bus.light_seq, bus.busy, bus.done}), 32'd0);
      @(negedge clk); #1 rst = 1'b0;
      dones = 0;
      repeat (40) begin @(negedge clk); dones += int'(bus.done); end
      chk("no_done_after_rst", 32'(dones), 32'd0);
      tick_rand = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk); #1;
         bus.play     = $urandom % 5 == 0;
         bus.play_len = 4'($urandom_range(0, 12));
         bus.seq_bus  = 16'($urandom);
         bus.abort    = $urandom % 30 == 0;
         bus.button   = 4'($urandom);
         if ($urandom % 80 == 0) bus.cleared = ~bus.cleared;
      end
      @(negedge clk); #1;
      bus.cleared = 1'b0; bus.play = 1'b0; bus.abort = 1'b0;
      repeat (5) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/t07_simon_light_player.md
T07_SIMON_LIGHT_PLAYER -- requirements
Module: t07_simon_light_player

Interface
REQ-001 SHALL have parameter NUM_COLORS, default 4: number of virtual buttons/colors, >=2.
REQ-002 SHALL have parameter MAX_LEN, default 8: maximum sequence entries, >=1.
REQ-003 SHALL have parameter LEAD_TICKS, default 3: dark ticks before the first entry, >=0.
REQ-004 SHALL have parameter ON_TICKS, default 2: ticks each entry is lit, >=1.
REQ-005 SHALL have parameter GAP_TICKS, default 1: dark ticks between entries, >=0.
REQ-006 SHALL derive CW = $clog2(NUM_COLORS) and LW = $clog2(MAX_LEN+1) as localparams.
REQ-007 clk  input  1  system clock, rising edge.
REQ-008 rst  input  1  asynchronous, active-high reset.
REQ-009 tick  input  1  one-cycle timing strobe.
REQ-010 play  input  1  start request, sampled in IDLE only.
REQ-011 play_len  input  LW  number of entries to show.
REQ-012 abort  input  1  cancel playback.
REQ-013 cleared  input  1  module solved, all lights on.
REQ-014 seq_bus  input  MAX_LEN*CW  entry i at bits [i*CW +: CW].
REQ-015 button  input  NUM_COLORS  raw one-hot physical buttons.
REQ-016 light_seq  output  NUM_COLORS  registered playback lights.
REQ-017 light_manual  output  NUM_COLORS  combinational press echo.
REQ-018 busy  output  1  high in LEAD, ON, GAP.
REQ-019 done  output  1  one-cycle pulse on normal completion.

Function
REQ-020 SHALL implement states IDLE, LEAD, ON, GAP, CLEAR; all outputs except light_manual registered.
REQ-021 IDLE: play=1 with play_len!=0 SHALL snapshot seq_bus and min(play_len,MAX_LEN), set idx=0, enter LEAD (or ON if LEAD_TICKS=0); play_len=0 ignored.
REQ-022 play outside IDLE SHALL be ignored; play and tick in same IDLE cycle: tick not counted.
REQ-023 LEAD: light_seq=0; after LEAD_TICKS ticks enter ON with idx=0.
REQ-024 ON: light_seq = one-hot of snapshot entry idx; entry value >= NUM_COLORS lights nothing but keeps timing.
REQ-025 ON after ON_TICKS ticks: if idx=len-1 go IDLE, light_seq=0, done=1 for one cycle; else GAP (or ON with idx+1 if GAP_TICKS=0).
REQ-026 GAP: light_seq=0; after GAP_TICKS ticks enter ON with idx+1; repeated colors SHALL show a dark gap.
REQ-027 Tick counter SHALL reload on every state entry and count only cycles with tick=1.
REQ-028 abort in LEAD/ON/GAP SHALL go IDLE next edge, light_seq=0, no done.
REQ-029 cleared SHALL have top priority: next edge enter CLEAR, light_seq all ones, busy=0, no done; stay while cleared=1; on deassert go IDLE, light_seq=0.
REQ-030 light_manual SHALL equal button when exactly one bit set, else all zero; independent of state.

Reset
REQ-031 rst=1 SHALL immediately force IDLE, idx=0, counter=0, snapshot=0, light_seq=0, busy=0, done=0.
REQ-032 rst mid-playback SHALL abort with no done pulse after release.

Structure
REQ-033 State enum and default parameter constants SHALL live in shared package t07_simon_pkg.
REQ-034 Tick counting SHALL be one sub-module, t07_simon_tick_timer (load value, tick enable, expired flag).

Verification (defaults NUM_COLORS=4, MAX_LEN=8, LEAD=3, ON=2, GAP=1; tick every 4 cycles)
REQ-035 play, len=3, entries 2,0,2 -> 3 dark ticks, 0100x2, 0000x1, 0001x2, 0000x1, 0100x2, done pulse one cycle after 11th tick, busy low.
REQ-036 len=2, entries 1,1 -> 0010, 0000, 0010 visible as two separate flashes.
REQ-037 cleared=1 during ON -> light_seq=1111 next cycle, busy=0; cleared=0 -> 0000, IDLE, done never pulses.
REQ-038 abort during GAP -> light_seq=0000, busy=0 next cycle, no done; subsequent play len=1 plays normally.
REQ-039 play_len=0 -> stays IDLE; play_len=12 -> exactly 8 entries played; play while busy ignored.
REQ-040 button=0100 -> light_manual=0100; button=0110 -> 0000; rst pulse mid-ON -> all outputs 0 without waiting for clk.
